// File: rtl/lib_bit_scan.sv
// -----------------------------------------------------------------------------
// lib_bit_scan
//
// Sequential set-bit enumerator. Accepts a WIDTH-bit vector plus a one-hot
// start position and emits the position of every set bit, one per output
// beat, in circular search order beginning at the start position. Each beat
// is found with a find-first-set over the still-pending bits, starting at the
// held base position and wrapping around the vector.
//
// Parameters
//   LSB_MSB : 1 = search from LSB toward MSB, 0 = search from MSB toward LSB.
//             The search is circular in both cases.
//   WIDTH   : vector width (>= 2). IDX_W is derived from it.
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   s_valid  in   input vector valid
//   s_ready  out  block can accept a vector (IDLE and not in reset)
//   s_vect   in   vector to enumerate
//   s_base   in   one-hot start position, sampled with s_vect
//   m_valid  out  output beat valid
//   m_ready  in   downstream accepts the beat
//   m_idx    out  binary position of the emitted bit
//   m_onehot out  one-hot of the emitted bit
//   m_last   out  final beat for the current vector
//   m_empty  out  vector had no set bits (single marker beat)
//
// States
//   IDLE | waiting for a vector, s_ready=1, m_valid=0
//   SCAN | emitting beats for the held vector, s_ready=0, m_valid=1
// -----------------------------------------------------------------------------
module lib_bit_scan #(
    parameter  int LSB_MSB = 0,
    parameter  int WIDTH   = 8,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_vect,
    input  logic [WIDTH-1:0] s_base,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [IDX_W-1:0] m_idx,
    output logic [WIDTH-1:0] m_onehot,
    output logic             m_last,
    output logic             m_empty
);

    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_BIT = {1'b1, {(WIDTH-1){1'b0}}};
    // Start position used when the caller supplies no base.
    localparam logic [WIDTH-1:0] DEFAULT_BASE = (LSB_MSB != 0) ? ONE : MSB_BIT;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] base;

    logic [WIDTH-1:0] base_clean;
    logic [WIDTH-1:0] ahead;
    logic [WIDTH-1:0] hit_ahead;
    logic [WIDTH-1:0] cur_onehot;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_last;
    logic             in_scan;

    // First set bit of v in search order, without wrap: lowest bit when
    // scanning upward, highest bit when scanning downward. The loop visits
    // bits in reverse search order so the last hit written is the first one.
    function automatic logic [WIDTH-1:0] first_in_order(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        int               j;
        r = '0;
        j = 0;
        for (int i = 0; i < WIDTH; i++) begin
            j = (LSB_MSB != 0) ? (WIDTH - 1 - i) : i;
            if (v[j]) begin
                r    = '0;
                r[j] = 1'b1;
            end
        end
        return r;
    endfunction

    // A zero base falls back to the default start; a multi-hot base keeps
    // only the bit that the search would reach first.
    always_comb begin
        base_clean = DEFAULT_BASE;
        if (s_base != '0) begin
            base_clean = first_in_order(s_base);
        end
    end

    // Circular find-first-set: look first at bits from base onward in search
    // direction (base inclusive); if none remain there, wrap and take the
    // first pending bit from the start of the search order. For a downward
    // scan with base at the MSB the shift overflows to zero and the mask
    // becomes all ones, which is the intended "everything is ahead" case.
    always_comb begin
        ahead = '0;
        if (LSB_MSB != 0) begin
            ahead = ~(base - ONE);
        end else begin
            ahead = (base << 1) - ONE;
        end
        hit_ahead  = pending & ahead;
        cur_onehot = '0;
        if (hit_ahead != '0) begin
            cur_onehot = first_in_order(hit_ahead);
        end else begin
            cur_onehot = first_in_order(pending);
        end
    end

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (cur_onehot[i]) begin
                cur_idx = cur_idx | IDX_W'(i);
            end
        end
    end

    // An empty vector also counts as last: pending is already zero.
    assign cur_last = ((pending & ~cur_onehot) == '0);
    assign in_scan  = (state == SCAN);

    // rst_n gates s_ready so the block never advertises readiness while it is
    // being held in reset; no data input reaches any output.
    assign s_ready  = (state == IDLE) && rst_n;
    assign m_valid  = in_scan;
    assign m_onehot = in_scan ? cur_onehot : '0;
    assign m_idx    = in_scan ? cur_idx : '0;
    assign m_last   = in_scan && cur_last;
    assign m_empty  = in_scan && (pending == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            base    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        pending <= s_vect;
                        base    <= base_clean;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (m_ready) begin
                        // base is held so the circular order stays anchored.
                        pending <= pending & ~cur_onehot;
                        if (cur_last) begin
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
